// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath sizes, status-flag bit positions and
// the writeback queue entry layout.
package cpu_pkg;

    localparam int WIDTH       = 16;
    localparam int REG_ADDR_W  = 3;
    localparam int QUEUE_DEPTH = 2;
    localparam int COUNT_W     = $clog2(QUEUE_DEPTH + 1);

    // Status register bit positions, packed as {N, Z, C, V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // One buffered ALU result waiting for the register-file write port
    typedef struct packed {
        logic [WIDTH-1:0]      data;
        logic [REG_ADDR_W-1:0] addr;
        logic                  wen;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Two-entry in-order result queue with push, pop and flush.
// Flush discards every entry and overrides a same-cycle push.
module wb_queue
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  wb_entry_t          push_entry,
    input  logic               pop,
    input  logic               flush,
    output wb_entry_t          head_entry,
    output logic [COUNT_W-1:0] count
);

    wb_entry_t mem [QUEUE_DEPTH];
    logic      head_ptr;
    logic      tail_ptr;
    logic      push_ok;
    logic      pop_ok;

    // Refuse pushes into a full queue and pops from an empty one
    assign push_ok = push && !flush && (count != COUNT_W'(QUEUE_DEPTH));
    assign pop_ok  = pop && (count != '0);

    // Entry storage: write the tail slot on push
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the storage is cleared on reset because the write port
            // reads it directly and must show zero address/data out of reset.
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            // NOTE: all clocked state uses non-blocking assignments so every
            // register samples the values from before the edge.
            mem[tail_ptr] <= push_entry;
        end
    end

    // Pointers and occupancy; flush empties the queue in one edge
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
            count    <= '0;
        end else begin
            if (push_ok) begin
                tail_ptr <= ~tail_ptr;
            end
            if (pop_ok) begin
                head_ptr <= ~head_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_entry = mem[head_ptr];

endmodule

// File: rtl/alu_writeback_stage.sv
// Execute-to-writeback stage: captures ALU results, updates the status
// flags at accept time and retires results in order to the register file.
module alu_writeback_stage #(
    parameter int WIDTH      = cpu_pkg::WIDTH,
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter int DEPTH      = cpu_pkg::QUEUE_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_result,
    input  logic                  in_zero,
    input  logic                  in_overflow,
    input  logic                  in_carry,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_wen,
    input  logic                  in_setflags,
    input  logic                  flush,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [WIDTH-1:0]      wb_data,
    output logic [3:0]            flags,
    output logic                  busy
);

    import cpu_pkg::*;

    wb_entry_t          push_entry;
    wb_entry_t          head_entry;
    logic [COUNT_W-1:0] count;
    logic               accept;
    logic               pop;

    // Ready depends on stored occupancy only, never on wb_ready
    assign in_ready = (count != COUNT_W'(DEPTH));
    assign busy     = (count != '0);
    assign accept   = in_valid && in_ready && !flush;

    // Writes to r0 are turned into no-write entries at capture
    assign push_entry.data = in_result;
    assign push_entry.addr = in_rd;
    assign push_entry.wen  = in_wen && (in_rd != '0);

    // Retire: write entries wait for the register file, others pop at once
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        wb_valid = 1'b0;
        pop      = 1'b0;
        if (busy) begin
            wb_valid = head_entry.wen;
            pop      = head_entry.wen ? wb_ready : 1'b1;
        end
    end

    assign wb_addr = head_entry.addr;
    assign wb_data = head_entry.data;

    // Status flags follow accepted results that request a flag update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags <= 4'b0000;
        end else if (accept && in_setflags) begin
            flags[FLAG_N] <= in_result[WIDTH-1];
            flags[FLAG_Z] <= in_zero;
            flags[FLAG_C] <= in_carry;
            flags[FLAG_V] <= in_overflow;
        end
    end

    wb_queue u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (accept),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (flush),
        .head_entry (head_entry),
        .count      (count)
    );

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage: a cycle model with a
// scoreboard queue checks every cycle, plus vector table and sequences.
module tb_alu_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic        in_zero;
    logic        in_overflow;
    logic        in_carry;
    logic [2:0]  in_rd;
    logic        in_wen;
    logic        in_setflags;
    logic        flush;
    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [3:0]  flags;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  addr;
        logic        wen;
    } sb_entry_t;

    typedef struct {
        logic [15:0] result;
        logic [2:0]  rd;
        logic        wen;
        logic        sf;
        logic        z;
        logic        c;
        logic        v;
        logic [3:0]  exp_flags;
        logic        exp_wv;
    } vec_t;

    sb_entry_t   m_q[$];
    logic [3:0]  m_flags = 4'b0000;
    logic [2:0]  wr_addr[$];
    logic [15:0] wr_data[$];
    logic        mon_en = 1'b0;
    logic        m_ready;
    logic        m_head_w;
    logic        m_push;
    logic        m_pop;

    alu_writeback_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_zero     (in_zero),
        .in_overflow (in_overflow),
        .in_carry    (in_carry),
        .in_rd       (in_rd),
        .in_wen      (in_wen),
        .in_setflags (in_setflags),
        .flush       (flush),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .flags       (flags),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [15:0] r, input logic [2:0] rd,
                         input logic wen, input logic sf, input logic z,
                         input logic c, input logic ovf);
        in_valid    = v;
        in_result   = r;
        in_rd       = rd;
        in_wen      = wen;
        in_setflags = sf;
        in_zero     = z;
        in_carry    = c;
        in_overflow = ovf;
    endtask

    // Cycle model: compares outputs mid-cycle, then advances to the next edge
    always @(negedge clk) begin
        m_ready  = (m_q.size() != 2);
        m_head_w = (m_q.size() != 0) && m_q[0].wen;
        if (mon_en) begin
            check("mon_in_ready", 32'(in_ready), 32'(m_ready));
            check("mon_busy", 32'(busy), 32'(m_q.size() != 0));
            check("mon_flags", 32'(flags), 32'(m_flags));
            check("mon_wb_valid", 32'(wb_valid), 32'(m_head_w));
            if (m_head_w) begin
                check("mon_wb_addr", 32'(wb_addr), 32'(m_q[0].addr));
                check("mon_wb_data", 32'(wb_data), 32'(m_q[0].data));
            end
        end
        if (rst_n && m_head_w && wb_ready) begin
            wr_addr.push_back(m_q[0].addr);
            wr_data.push_back(m_q[0].data);
        end
        m_pop  = (m_q.size() != 0) && (!m_q[0].wen || wb_ready);
        m_push = in_valid && m_ready && !flush;
        if (!rst_n) begin
            m_q.delete();
            m_flags = 4'b0000;
        end else begin
            if (m_push && in_setflags)
                m_flags = {in_result[15], in_zero, in_carry, in_overflow};
            if (flush) begin
                m_q.delete();
            end else begin
                if (m_pop) void'(m_q.pop_front());
                if (m_push) m_q.push_back('{in_result, in_rd, in_wen && (in_rd != 3'd0)});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required self-termination");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   n0;

        vecs[0] = '{16'h1234, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b1};
        vecs[1] = '{16'h8000, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1011, 1'b1};
        vecs[2] = '{16'h0000, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1011, 1'b1};
        vecs[3] = '{16'hFFFF, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1};
        vecs[4] = '{16'h0000, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0110, 1'b0};
        vecs[5] = '{16'h5555, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0};

        rst_n    = 1'b0;
        flush    = 1'b0;
        wb_ready = 1'b1;
        drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_wb_addr", 32'(wb_addr), 32'd0);
        check("rst_wb_data", 32'(wb_data), 32'd0);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        tick();

        // Vector table: one result into an empty queue, wb_ready high
        for (int i = 0; i < 6; i++) begin
            n0 = wr_addr.size();
            drive(1'b1, vecs[i].result, vecs[i].rd, vecs[i].wen, vecs[i].sf,
                  vecs[i].z, vecs[i].c, vecs[i].v);
            tick();
            drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].exp_flags));
            check($sformatf("vec%0d_wb_valid", i), 32'(wb_valid), 32'(vecs[i].exp_wv));
            if (vecs[i].exp_wv) begin
                check($sformatf("vec%0d_wb_addr", i), 32'(wb_addr), 32'(vecs[i].rd));
                check($sformatf("vec%0d_wb_data", i), 32'(wb_data), 32'(vecs[i].result));
            end
            tick();
            check($sformatf("vec%0d_busy_after", i), 32'(busy), 32'd0);
            check($sformatf("vec%0d_nwrites", i), 32'(wr_addr.size()), 32'(n0 + int'(vecs[i].exp_wv)));
        end

        // Back-pressure: fill, ignore a third result, then drain in order
        n0 = wr_addr.size();
        wb_ready = 1'b0;
        drive(1'b1, 16'h0001, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0002, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("bp_in_ready_full", 32'(in_ready), 32'd0);
        drive(1'b1, 16'h0003, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("bp_hold_addr", 32'(wb_addr), 32'd1);
        check("bp_hold_data", 32'(wb_data), 32'h0001);
        drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wb_ready = 1'b1;
        tick();
        check("bp_ready_after_pop", 32'(in_ready), 32'd1);
        check("bp_second_addr", 32'(wb_addr), 32'd2);
        tick();
        check("bp_empty", 32'(busy), 32'd0);
        check("bp_nwrites", 32'(wr_addr.size()), 32'(n0 + 2));
        if (wr_addr.size() == n0 + 2) begin
            check("bp_w0", {13'd0, wr_addr[n0], wr_data[n0]}, {13'd0, 3'd1, 16'h0001});
            check("bp_w1", {13'd0, wr_addr[n0+1], wr_data[n0+1]}, {13'd0, 3'd2, 16'h0002});
        end

        // r0 and no-write entries retire without a write, even with wb_ready low
        n0 = wr_addr.size();
        wb_ready = 1'b0;
        drive(1'b1, 16'h00AA, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("nw_busy1", 32'(busy), 32'd1);
        check("nw_valid1", 32'(wb_valid), 32'd0);
        drive(1'b1, 16'h00BB, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("nw_busy2", 32'(busy), 32'd1);
        check("nw_valid2", 32'(wb_valid), 32'd0);
        drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("nw_busy3", 32'(busy), 32'd0);
        check("nw_nwrites", 32'(wr_addr.size()), 32'(n0));

        // Flush with one pending entry and a same-cycle input
        n0 = wr_addr.size();
        drive(1'b1, 16'h0AAA, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check("fl_flags_pre", 32'(flags), 32'b0001);
        drive(1'b1, 16'hFBBB, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("fl_busy", 32'(busy), 32'd0);
        check("fl_wb_valid", 32'(wb_valid), 32'd0);
        check("fl_in_ready", 32'(in_ready), 32'd1);
        check("fl_flags_kept", 32'(flags), 32'b0001);
        wb_ready = 1'b1;
        tick();
        tick();
        check("fl_nwrites", 32'(wr_addr.size()), 32'(n0));

        // Flush on a full queue while the head write is accepted
        n0 = wr_addr.size();
        wb_ready = 1'b0;
        drive(1'b1, 16'h0111, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0222, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        flush    = 1'b1;
        wb_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("flw_busy", 32'(busy), 32'd0);
        tick();
        check("flw_nwrites", 32'(wr_addr.size()), 32'(n0 + 1));
        if (wr_addr.size() == n0 + 1)
            check("flw_w0", {13'd0, wr_addr[n0], wr_data[n0]}, {13'd0, 3'd1, 16'h0111});

        // Reset in the middle of a stalled, full queue
        n0 = wr_addr.size();
        wb_ready = 1'b0;
        drive(1'b1, 16'h8123, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 16'h0456, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("mr_full", 32'(in_ready), 32'd0);
        check("mr_flags_pre", 32'(flags), 32'b1011);
        drive(1'b1, 16'h0789, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        flush = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        flush = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mr_in_ready", 32'(in_ready), 32'd1);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_wb_valid", 32'(wb_valid), 32'd0);
        check("mr_wb_addr", 32'(wb_addr), 32'd0);
        check("mr_wb_data", 32'(wb_data), 32'd0);
        check("mr_flags", 32'(flags), 32'd0);
        wb_ready = 1'b1;
        tick();
        tick();
        check("mr_nwrites", 32'(wr_addr.size()), 32'(n0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_writeback_stage.md
# alu_writeback_stage

Execute-to-writeback stage sitting directly downstream of the 16-bit ALU. Captures each ALU result with its Zero/Overflow/CarryOut flags and destination tag, updates the architectural status-flag register, and buffers results in a 2-entry queue. Results are presented to the register-file write port with a valid/ready handshake, so register-file back-pressure never forces the ALU to recompute.

## Interface
Parameters:
- WIDTH, 16, datapath width (ALU result and writeback data)
- REG_ADDR_W, 3, register-file address width (8 registers, r0 hard-wired zero)
- DEPTH, 2, result queue depth (fixed at 2; other values unsupported)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  ALU result valid this cycle
- in_ready  out  1  stage can accept a result; registered, equals (count != DEPTH)
- in_result  in  WIDTH  ALU Result
- in_zero  in  1  ALU Zero
- in_overflow  in  1  ALU Overflow
- in_carry  in  1  ALU CarryOut
- in_rd  in  REG_ADDR_W  destination register
- in_wen  in  1  instruction writes a register
- in_setflags  in  1  instruction updates status flags
- flush  in  1  discard all queued results (branch mispredict / trap)
- wb_valid  out  1  head entry requests a register write
- wb_ready  in  1  register file accepts write
- wb_addr  out  REG_ADDR_W  write address
- wb_data  out  WIDTH  write data
- flags  out  4  status register {N, Z, C, V}
- busy  out  1  queue non-empty

## Operation
- Accept: in_valid && in_ready at rising edge pushes {in_result, in_rd, in_wen && (in_rd != 0)} at the tail.
- Flags: on accept with in_setflags=1, flags <= {in_result[WIDTH-1], in_zero, in_carry, in_overflow}. in_setflags=0 leaves flags unchanged. Flags update at accept, not at retire.
- Head retire: if head.wen=1, wb_valid=1 and the head pops on wb_valid && wb_ready. If head.wen=0 (includes rd=r0), wb_valid=0 and the head pops unconditionally that cycle.
- Order: strictly in order; at most one push and one pop per cycle.
- Simultaneous push and pop: allowed whenever in_ready=1; count unchanged. When full, in_ready=0 even if a pop happens this cycle (no combinational wb_ready -> in_ready path).
- Flush: on flush=1, count, head and tail pointers clear next edge; any same-cycle push is dropped; the same-cycle pop still completes only if wb_valid && wb_ready (the write is already committed). Flags are not rolled back.
- Pointers: 1-bit head/tail, wrap modulo 2; count 0..2.
- Reset (rst_n=0 at edge): count=0, pointers=0, flags=4'b0000, in_ready=1, wb_valid=0, wb_addr=0, wb_data=0, busy=0. Reset overrides flush and push.

## Timing
- Push at edge N into empty queue: wb_valid=1 during cycle N+1 (1-cycle latency).
- Flags reflect an accepted result from cycle N+1.
- Full throughput: one result per cycle with wb_ready held high.
- wb_addr/wb_data driven from queue storage; stable while wb_valid=1 && wb_ready=0.
- in_ready, busy, wb_valid are functions of registered state only.

## Structure
- Shared package cpu_pkg: WIDTH, REG_ADDR_W, flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0, and the queue-entry typedef {data, addr, wen}.
- One sub-module: wb_queue (2-entry synchronous FIFO with push/pop/flush, count output); flag register and retire logic live in alu_writeback_stage.

## Test plan
- Reset then single push: result 16'h1234, rd=3, wen=1, setflags=1, zero=0, carry=1, overflow=0, wb_ready=1 -> next cycle wb_valid=1, wb_addr=3, wb_data=16'h1234, flags=4'b0010; queue empty the cycle after.
- Back-pressure: wb_ready=0, push 16'h0001 (rd=1), 16'h0002 (rd=2) -> in_ready=0 after second push, third in_valid ignored; raise wb_ready -> writes rd1 then rd2 in consecutive cycles, in_ready returns to 1 the cycle after first pop.
- r0 / no-write entries: push rd=0 wen=1 and rd=5 wen=0 -> wb_valid never asserted, each entry retires in one cycle, busy drops after 2 cycles.
- Flags: push 16'h8000 with overflow=1, carry=1, setflags=1 -> flags=4'b1011; then push 16'h0000 zero=1 setflags=0 -> flags stay 4'b1011.
- Flush with pending entries and same-cycle in_valid -> next cycle count=0, wb_valid=0, in_ready=1, flags unchanged; dropped input never written.
- Reset mid-operation: queue full, wb_ready=0, rst_n=0 for one edge -> all outputs at reset values, flags=0, no write issued.
